// File: rtl/ssd_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ssd_display_arbiter
// Description : Round-robin arbiter sharing one 4-digit seven-segment display
//               path between three sources (servo position, SPI joystick
//               sample, debug value). Each grant holds the display for at
//               least DWELL_CYCLES. The granted value is routed to the display
//               controller, and a one-cycle START pulse kicks the BCD
//               converter both periodically and right after a source switch.
// Ports       : CLK        - system clock
//               RST        - synchronous active-high reset
//               REQ[2:0]   - level-sensitive request, bit i = source i
//               DIN0..2    - 10-bit source values
//               GNT[2:0]   - one-hot grant, zero when idle
//               SRC[1:0]   - current or last granted source index
//               DOUT[9:0]  - value routed to the display controller
//               DOUT_VALID - high while a grant is active
//               START      - one-cycle BCD conversion start pulse
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_display_arbiter #(
  parameter int DWELL_CYCLES = 100000000,
  parameter int REFRESH_DIV  = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] REQ,
  input  logic [9:0] DIN0,
  input  logic [9:0] DIN1,
  input  logic [9:0] DIN2,
  output logic [2:0] GNT,
  output logic [1:0] SRC,
  output logic [9:0] DOUT,
  output logic       DOUT_VALID,
  output logic       START
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] c_dwell_load  = DW'(DWELL_CYCLES - 1);
  localparam logic [RW-1:0] c_refresh_top = RW'(REFRESH_DIV - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_last, w_last_nxt;
  logic [DW-1:0] r_dwell, w_dwell_nxt;
  logic [RW-1:0] r_refresh, w_refresh_nxt;
  logic [2:0]    r_gnt, w_gnt_nxt;
  logic [1:0]    r_src, w_src_nxt;
  logic [9:0]    r_dout, w_dout_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_start, w_start_nxt;
  logic          r_pend;        // a grant or switch happened on the last edge
  logic          w_grant_evt;
  logic [2:0]    w_others;
  logic [2:0]    w_pool;
  logic [1:0]    w_win;

  // Round-robin pick: search from (last+1) mod 3 upward with wrap.
  function automatic logic [1:0] f_rr(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] r;
    case (last)
      2'd0:    r = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    r = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: r = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
    return r;
  endfunction

  function automatic logic [9:0] f_din(input logic [1:0] idx,
                                       input logic [9:0] d0,
                                       input logic [9:0] d1,
                                       input logic [9:0] d2);
    logic [9:0] v;
    case (idx)
      2'd0:    v = d0;
      2'd1:    v = d1;
      default: v = d2;
    endcase
    return v;
  endfunction

  // At dwell expiry with the owner still requesting, only the other
  // requesters compete; in every other case the whole request vector does.
  always_comb begin
    w_others        = REQ;
    w_others[r_src] = 1'b0;
    w_pool = (r_state == ST_HOLD && REQ[r_src]) ? w_others : REQ;
    w_win  = f_rr(w_pool, r_last);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_dwell_nxt = r_dwell;
    w_gnt_nxt   = r_gnt;
    w_src_nxt   = r_src;
    w_dout_nxt  = r_dout;
    w_valid_nxt = r_valid;
    w_grant_evt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt   = 3'b000;
        w_valid_nxt = 1'b0;
        if (|REQ) begin
          w_grant_evt = 1'b1;
        end
      end
      default: begin
        w_dout_nxt = f_din(r_src, DIN0, DIN1, DIN2);
        if (r_dwell != '0) begin
          w_dwell_nxt = r_dwell - 1'b1;
        end
        if (!REQ[r_src]) begin
          // Early release takes precedence over a coincident expiry.
          if (|REQ) begin
            w_grant_evt = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = 3'b000;
            w_valid_nxt = 1'b0;
            w_dout_nxt  = r_dout;
            w_last_nxt  = r_src;
          end
        end else if (r_dwell == '0) begin
          if (|w_others) begin
            w_grant_evt = 1'b1;
          end else begin
            w_dwell_nxt = c_dwell_load;
          end
        end
      end
    endcase

    if (w_grant_evt) begin
      w_state_nxt = ST_HOLD;
      w_gnt_nxt   = 3'b001 << w_win;
      w_src_nxt   = w_win;
      w_last_nxt  = w_win;
      w_dout_nxt  = f_din(w_win, DIN0, DIN1, DIN2);
      w_valid_nxt = 1'b1;
      w_dwell_nxt = c_dwell_load;
    end

    // The switch pulse lands one cycle after GNT changes and re-phases the
    // refresh counter; a coincident periodic pulse merges into it. START is
    // suppressed whenever the next cycle is idle.
    w_start_nxt = w_valid_nxt &&
                  (r_pend || (r_valid && (r_refresh == c_refresh_top)));
    if (r_pend || (r_refresh == c_refresh_top)) begin
      w_refresh_nxt = '0;
    end else begin
      w_refresh_nxt = r_refresh + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_last    <= 2'd2;
      r_dwell   <= '0;
      r_refresh <= '0;
      r_gnt     <= 3'b000;
      r_src     <= 2'd0;
      r_dout    <= 10'd0;
      r_valid   <= 1'b0;
      r_start   <= 1'b0;
      r_pend    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_dwell   <= w_dwell_nxt;
      r_refresh <= w_refresh_nxt;
      r_gnt     <= w_gnt_nxt;
      r_src     <= w_src_nxt;
      r_dout    <= w_dout_nxt;
      r_valid   <= w_valid_nxt;
      r_start   <= w_start_nxt;
      r_pend    <= w_grant_evt;
    end
  end

  assign GNT        = r_gnt;
  assign SRC        = r_src;
  assign DOUT       = r_dout;
  assign DOUT_VALID = r_valid;
  assign START      = r_start;

endmodule
`default_nettype wire

// File: tb/tb_ssd_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_display_arbiter
// Description : Self-checking bench for ssd_display_arbiter with
//               DWELL_CYCLES=8 and REFRESH_DIV=16. A behavioural model tracks
//               grant start times and the refresh phase with plain arithmetic;
//               scenario tasks add directed expectations on top.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_display_arbiter;

  localparam int DWELL = 8;
  localparam int RDIV  = 16;

  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] REQ;
  logic [9:0] DIN0, DIN1, DIN2;
  logic [2:0] GNT;
  logic [1:0] SRC;
  logic [9:0] DOUT;
  logic       DOUT_VALID;
  logic       START;

  int checks   = 0;
  int failures = 0;

  ssd_display_arbiter #(.DWELL_CYCLES(DWELL), .REFRESH_DIV(RDIV)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .DIN0(DIN0), .DIN1(DIN1), .DIN2(DIN2),
    .GNT(GNT), .SRC(SRC), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .START(START)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural reference model ----------------
  int         t        = 0;   // posedge count
  bit         m_valid  = 0;
  int         m_src    = 0;
  int         m_last   = 2;
  int         m_gtime  = 0;   // edge at which the current dwell period began
  int         m_anchor = 0;   // edge at which the refresh count was last 0
  bit         m_pend   = 0;
  bit         m_start  = 0;
  logic [9:0] m_dout   = '0;

  function automatic int rr_pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) begin
      if (r[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [9:0] din(input int i);
    return (i == 0) ? DIN0 : ((i == 1) ? DIN1 : DIN2);
  endfunction

  always @(posedge CLK) begin
    bit         pv, pend;
    int         pcnt, win;
    logic [2:0] msk;
    t++;
    pv   = m_valid;
    pcnt = (t - 1 - m_anchor) % RDIV;
    pend = m_pend;
    m_pend = 0;
    if (RST) begin
      m_valid = 0; m_src = 0; m_last = 2; m_dout = '0;
      m_start = 0; m_anchor = t;
    end else begin
      win = -1;
      if (!m_valid) begin
        win = rr_pick(REQ, m_last);
      end else if (!REQ[m_src]) begin
        win = rr_pick(REQ, m_last);
        if (win < 0) begin
          m_valid = 0;
          m_last  = m_src;
        end
      end else if (t - m_gtime >= DWELL) begin
        msk = REQ;
        msk[m_src] = 1'b0;
        win = rr_pick(msk, m_last);
        if (win < 0) begin
          m_gtime = t;
          m_dout  = din(m_src);
        end
      end else begin
        m_dout = din(m_src);
      end
      if (win >= 0) begin
        m_valid = 1; m_src = win; m_last = win;
        m_dout = din(win); m_gtime = t; m_pend = 1;
      end
      m_start = m_valid && (pend || (pv && pcnt == RDIV - 1));
      if (pend) m_anchor = t;
    end
  end

  function automatic logic [16:0] exp_vec();
    logic [2:0] g;
    g = m_valid ? (3'b001 << m_src) : 3'b000;
    return {g, 2'(m_src), m_dout, m_valid, m_start};
  endfunction

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    REQ = 3'b000; DIN0 = 10'd1; DIN1 = 10'd2; DIN2 = 10'd3;
    do_reset();
    checks++;
    if ({GNT, SRC, DOUT, DOUT_VALID, START} !== 17'd0) begin
      failures++;
      $display("FAIL reset: got gnt=%b src=%0d dout=%0d valid=%b start=%b, want all zero",
               GNT, SRC, DOUT, DOUT_VALID, START);
    end
  endtask

  task automatic test_first_grant();
    do_reset();
    REQ = 3'b001; DIN0 = 10'd345;
    step();
    checks++;
    if ({GNT, SRC, DOUT, DOUT_VALID, START} !== {3'b001, 2'd0, 10'd345, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL first_grant: got gnt=%b src=%0d dout=%0d valid=%b start=%b, want 001/0/345/1/0",
               GNT, SRC, DOUT, DOUT_VALID, START);
    end
    step();
    checks++;
    if (START !== 1'b1) begin
      failures++;
      $display("FAIL first_grant_start: got start=%b, want 1", START);
    end
    for (int i = 1; i <= 33; i++) begin
      step();
      checks++;
      if (START !== ((i % RDIV) == 0)) begin
        failures++;
        $display("FAIL periodic_start: cycle %0d got start=%b, want %b", i, START, (i % RDIV) == 0);
      end
    end
  endtask

  task automatic test_rotation();
    do_reset();
    REQ = 3'b111;
    for (int i = 0; i < 32; i++) begin
      logic [2:0] eg;
      step();
      eg = 3'b001 << ((i / DWELL) % 3);
      checks++;
      if (GNT !== eg || START !== ((i % DWELL) == 1)) begin
        failures++;
        $display("FAIL rotation: cycle %0d got gnt=%b start=%b, want gnt=%b start=%b",
                 i, GNT, START, eg, (i % DWELL) == 1);
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    REQ = 3'b010;
    step();
    step();
    step();           // dwell count now 5
    REQ = 3'b100;
    step();
    checks++;
    if (GNT !== 3'b100 || SRC !== 2'd2 || DOUT_VALID !== 1'b1) begin
      failures++;
      $display("FAIL early_release: got gnt=%b src=%0d valid=%b, want 100/2/1", GNT, SRC, DOUT_VALID);
    end
  endtask

  task automatic test_single_source();
    int pulses;
    do_reset();
    REQ = 3'b010; DIN1 = 10'd100;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 20) DIN1 = 10'd900;
      if (i == 21) begin
        checks++;
        if (DOUT !== 10'd900) begin
          failures++;
          $display("FAIL din_track: got dout=%0d, want 900", DOUT);
        end
      end
      if (START === 1'b1) pulses++;
      checks++;
      if (GNT !== 3'b010 || {GNT, SRC, DOUT, DOUT_VALID, START} !== exp_vec()) begin
        failures++;
        $display("FAIL single_source: cycle %0d got %h want %h", i,
                 {GNT, SRC, DOUT, DOUT_VALID, START}, exp_vec());
      end
    end
    // switch pulse at cycle 1, periodic at 17 and 33
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL single_source_pulses: got %0d pulses, want 3", pulses);
    end
  endtask

  task automatic test_release_idle();
    do_reset();
    REQ = 3'b001; DIN0 = 10'd512;
    step(); step(); step();
    REQ = 3'b000;
    step();
    checks++;
    if ({GNT, DOUT, DOUT_VALID, START} !== {3'b000, 10'd512, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL release_idle: got gnt=%b dout=%0d valid=%b start=%b, want 000/512/0/0",
               GNT, DOUT, DOUT_VALID, START);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (START !== 1'b0 || GNT !== 3'b000) begin
        failures++;
        $display("FAIL idle_quiet: cycle %0d got start=%b gnt=%b, want 0/000", i, START, GNT);
      end
    end
    REQ = 3'b011;
    step();
    checks++;
    if (GNT !== 3'b010 || SRC !== 2'd1) begin
      failures++;
      $display("FAIL pointer_after_idle: got gnt=%b src=%0d, want 010/1", GNT, SRC);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    REQ = 3'b111;
    for (int i = 0; i < 11; i++) step();
    RST = 1'b1;
    step();
    checks++;
    if ({GNT, SRC, DOUT, DOUT_VALID, START} !== 17'd0) begin
      failures++;
      $display("FAIL reset_mid: got gnt=%b src=%0d dout=%0d valid=%b start=%b, want all zero",
               GNT, SRC, DOUT, DOUT_VALID, START);
    end
    RST = 1'b0;
    step();
    checks++;
    if (GNT !== 3'b001 || SRC !== 2'd0 || DOUT_VALID !== 1'b1 || START !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_regrant: got gnt=%b src=%0d valid=%b start=%b, want 001/0/1/0",
               GNT, SRC, DOUT_VALID, START);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) REQ = 3'($urandom_range(0, 7));
      DIN0 = 10'($urandom_range(0, 1023));
      DIN1 = 10'($urandom_range(0, 1023));
      DIN2 = 10'($urandom_range(0, 1023));
      RST  = ($urandom_range(0, 499) == 0);
      step();
      checks++;
      if ({GNT, SRC, DOUT, DOUT_VALID, START} !== exp_vec() || $countones(GNT) > 1) begin
        failures++;
        $display("FAIL random: cycle %0d got gnt=%b src=%0d dout=%0d valid=%b start=%b, want %h",
                 i, GNT, SRC, DOUT, DOUT_VALID, START, exp_vec());
      end
    end
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; REQ = 3'b000; DIN0 = '0; DIN1 = '0; DIN2 = '0;
    test_reset();
    test_first_grant();
    test_rotation();
    test_early_release();
    test_single_source();
    test_release_idle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
